// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared encodings for the branch predictor (counter states,
//               FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Next value of a 2-bit saturating branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    input  logic       jump_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (jump_i) begin
            cnt_o = ST;
        end else if (taken_i) begin
            if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, clear sweep and stats.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         DBITS     = 16,
    parameter int         ENTRIES   = 16,
    parameter logic [1:0] CNT_ALLOC = 2'b10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] lk_pc,
    output logic             pred_taken,
    output logic [DBITS-1:0] pred_target,
    input  logic             upd_valid,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    input  logic             upd_jump,
    input  logic             upd_mispred,
    input  logic             inv,
    output logic             ready,
    output logic [DBITS-1:0] br_count,
    output logic [DBITS-1:0] mispred_count
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = DBITS - IDX - 1;
    localparam logic [DBITS-1:0] C_ALL_ONES = {DBITS{1'b1}};

    state_e           state_q, state_d;
    logic [IDX-1:0]   sweep_q, sweep_d;

    logic             valid_q [ENTRIES];
    logic [TAGW-1:0]  tag_q   [ENTRIES];
    logic [DBITS-1:0] tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic [DBITS-1:0] br_count_q, mispred_count_q;

    logic [IDX-1:0]   w_lk_idx, w_upd_idx;
    logic [TAGW-1:0]  w_lk_tag, w_upd_tag;
    logic             w_lk_hit, w_upd_hit, w_upd_acc;
    logic [1:0]       w_cnt_next;
    logic             w_unused_pc0;

    // Instructions are 2-byte aligned, so pc[0] never participates.
    assign w_unused_pc0 = lk_pc[0] ^ upd_pc[0];

    assign w_lk_idx  = lk_pc[IDX:1];
    assign w_lk_tag  = lk_pc[DBITS-1:IDX+1];
    assign w_upd_idx = upd_pc[IDX:1];
    assign w_upd_tag = upd_pc[DBITS-1:IDX+1];

    assign ready       = (state_q == RUN);
    assign w_lk_hit    = ready && valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign pred_taken  = w_lk_hit && cnt_q[w_lk_idx][1];
    assign pred_target = w_lk_hit ? tgt_q[w_lk_idx] : lk_pc + DBITS'(2);

    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
    // An update coinciding with inv is dropped along with the old contents.
    assign w_upd_acc = upd_valid && ready && !inv && !reset;

    sat_counter2 u_sat_counter2 (
        .cnt_i   (cnt_q[w_upd_idx]),
        .taken_i (upd_taken),
        .jump_i  (upd_jump),
        .cnt_o   (w_cnt_next)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            CLEAR: begin
                sweep_d = sweep_q + IDX'(1);
                if (sweep_q == IDX'(ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                if (inv) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!ready) begin
            valid_q[sweep_q] <= 1'b0;
            cnt_q[sweep_q]   <= WNT;
        end else if (w_upd_acc) begin
            if (w_upd_hit) begin
                tgt_q[w_upd_idx] <= upd_target;
                cnt_q[w_upd_idx] <= w_cnt_next;
            end else if (upd_taken) begin
                valid_q[w_upd_idx] <= 1'b1;
                tag_q[w_upd_idx]   <= w_upd_tag;
                tgt_q[w_upd_idx]   <= upd_target;
                cnt_q[w_upd_idx]   <= upd_jump ? 2'(ST) : CNT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (w_upd_acc) begin
            if (br_count_q != C_ALL_ONES) br_count_q <= br_count_q + DBITS'(1);
            if (upd_mispred && (mispred_count_q != C_ALL_ONES))
                mispred_count_q <= mispred_count_q + DBITS'(1);
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Randomized and directed checks of branch_predictor against a
//               behavioural BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int DBITS   = 16;
    localparam int ENTRIES = 16;
    localparam int IDX     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DBITS-1:0] lk_pc = '0;
    logic             pred_taken;
    logic [DBITS-1:0] pred_target;
    logic             upd_valid = 1'b0;
    logic [DBITS-1:0] upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [DBITS-1:0] upd_target = '0;
    logic             upd_jump = 1'b0;
    logic             upd_mispred = 1'b0;
    logic             inv = 1'b0;
    logic             ready;
    logic [DBITS-1:0] br_count;
    logic [DBITS-1:0] mispred_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: per-slot contents plus cycles left in the clear
    bit m_valid [ENTRIES];
    int m_tag   [ENTRIES];
    int m_tgt   [ENTRIES];
    int m_cnt   [ENTRIES];
    int m_clear = 0;
    int m_br    = 0;
    int m_mp    = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .DBITS     (DBITS),
        .ENTRIES   (ENTRIES),
        .CNT_ALLOC (2'b10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lk_pc         (lk_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_jump      (upd_jump),
        .upd_mispred   (upd_mispred),
        .inv           (inv),
        .ready         (ready),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    function automatic int idx_of(input int pc);
        return (pc / 2) % ENTRIES;
    endfunction

    function automatic int tag_of(input int pc);
        return pc / (2 * ENTRIES);
    endfunction

    function automatic void m_wipe();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_step();
        int i;
        bit hit;
        if (reset) begin
            m_clear = ENTRIES;
            m_br    = 0;
            m_mp    = 0;
            m_wipe();
        end else if (m_clear > 0) begin
            m_clear = m_clear - 1;
        end else if (inv) begin
            m_clear = ENTRIES;
            m_wipe();
        end else if (upd_valid) begin
            i   = idx_of(int'(upd_pc));
            hit = m_valid[i] && (m_tag[i] == tag_of(int'(upd_pc)));
            if (hit) begin
                m_tgt[i] = int'(upd_target);
                if (upd_jump)       m_cnt[i] = 3;
                else if (upd_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                else                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(int'(upd_pc));
                m_tgt[i]   = int'(upd_target);
                m_cnt[i]   = upd_jump ? 3 : 2;
            end
            if (m_br < 65535) m_br = m_br + 1;
            if (upd_mispred && m_mp < 65535) m_mp = m_mp + 1;
        end
    endfunction

    function automatic void m_lookup(input int pc, output bit t, output int tg);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = (m_clear == 0) && m_valid[i] && (m_tag[i] == tag_of(pc));
        t   = hit && (m_cnt[i] >= 2);
        tg  = hit ? m_tgt[i] : ((pc + 2) % 65536);
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_update(input int pc, input bit tk, input int tgt, input bit jmp, input bit mp);
        upd_valid   = 1'b1;
        upd_pc      = DBITS'(pc);
        upd_taken   = tk;
        upd_target  = DBITS'(tgt);
        upd_jump    = jmp;
        upd_mispred = mp;
        clock_edge();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        upd_jump    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_low cycle=%0d got=%b expected=0", i, ready);
            end
            clock_edge();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise got=%b expected=1", ready);
        end
        lk_pc = 16'h0200;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 16'h0202) begin
            n_fail++;
            $display("FAIL reset_lookup got=%b/%h expected=0/0202", pred_taken, pred_target);
        end
        n_checks++;
        if (br_count !== 16'h0 || mispred_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts got=%h/%h expected=0000/0000", br_count, mispred_count);
        end
    endtask

    task automatic test_allocate();
        do_update(16'h0204, 1'b1, 16'h0220, 1'b0, 1'b0);
        lk_pc = 16'h0204;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 16'h0220) begin
            n_fail++;
            $display("FAIL allocate_lookup got=%b/%h expected=1/0220", pred_taken, pred_target);
        end
        n_checks++;
        if (br_count !== 16'd1) begin
            n_fail++;
            $display("FAIL allocate_br_count got=%h expected=0001", br_count);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 3; i++) do_update(16'h0204, 1'b1, 16'h0220, 1'b0, 1'b0);
        do_update(16'h0204, 1'b0, 16'h0220, 1'b0, 1'b1);
        lk_pc = 16'h0204;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL hyst_one_nt got=%b expected=1", pred_taken);
        end
        do_update(16'h0204, 1'b0, 16'h0220, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 16'h0220) begin
            n_fail++;
            $display("FAIL hyst_two_nt got=%b/%h expected=0/0220", pred_taken, pred_target);
        end
        n_checks++;
        if (br_count !== 16'd6 || mispred_count !== 16'd2) begin
            n_fail++;
            $display("FAIL hyst_counts got=%h/%h expected=0006/0002", br_count, mispred_count);
        end
        do_update(16'h0204, 1'b0, 16'h0230, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 16'h0230) begin
            n_fail++;
            $display("FAIL jump_forces_st got=%b/%h expected=1/0230", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        lk_pc = 16'h0224;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 16'h0226) begin
            n_fail++;
            $display("FAIL alias_lookup got=%b/%h expected=0/0226", pred_taken, pred_target);
        end
        do_update(16'h0226, 1'b0, 16'h0300, 1'b0, 1'b0);
        lk_pc = 16'h0206;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 16'h0208) begin
            n_fail++;
            $display("FAIL nt_miss_no_alloc got=%b/%h expected=0/0208", pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        bit exp_t;
        int exp_tg;
        for (int n = 0; n < 400; n++) begin
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = DBITS'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            upd_taken   = $urandom_range(0, 1);
            upd_target  = DBITS'($urandom);
            upd_jump    = ($urandom_range(0, 7) == 0);
            upd_mispred = $urandom_range(0, 1);
            inv         = ($urandom_range(0, 59) == 0);
            lk_pc       = DBITS'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            #1;
            m_lookup(int'(lk_pc), exp_t, exp_tg);
            n_checks++;
            if (pred_taken !== exp_t || pred_target !== DBITS'(exp_tg) || ready !== (m_clear == 0)) begin
                n_fail++;
                $display("FAIL random_lookup n=%0d pc=%h got=%b/%h/%b expected=%b/%h/%b",
                         n, lk_pc, pred_taken, pred_target, ready, exp_t, DBITS'(exp_tg), (m_clear == 0));
            end
            clock_edge();
            n_checks++;
            if (br_count !== DBITS'(m_br) || mispred_count !== DBITS'(m_mp)) begin
                n_fail++;
                $display("FAIL random_counts n=%0d got=%h/%h expected=%h/%h",
                         n, br_count, mispred_count, DBITS'(m_br), DBITS'(m_mp));
            end
        end
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        upd_jump    = 1'b0;
        inv         = 1'b0;
        while (m_clear != 0) clock_edge();
    endtask

    task automatic test_invalidate();
        int br0, mp0;
        do_update(16'h0204, 1'b1, 16'h0220, 1'b0, 1'b0);
        br0 = int'(br_count);
        mp0 = int'(mispred_count);
        inv = 1'b1;
        do_update(16'h0300, 1'b1, 16'h0340, 1'b0, 1'b1);
        inv = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_ready_low cycle=%0d got=%b expected=0", i, ready);
            end
            if (i == 5) begin
                inv = 1'b1;
                do_update(16'h0208, 1'b1, 16'h0250, 1'b0, 1'b1);
                inv = 1'b0;
            end else if (i == 9) begin
                do_update(16'h020A, 1'b1, 16'h0260, 1'b0, 1'b1);
            end else begin
                clock_edge();
            end
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_ready_rise got=%b expected=1", ready);
        end
        n_checks++;
        if (int'(br_count) != br0 || int'(mispred_count) != mp0) begin
            n_fail++;
            $display("FAIL inv_counts got=%h/%h expected=%h/%h", br_count, mispred_count, DBITS'(br0), DBITS'(mp0));
        end
        for (int p = 0; p < 4; p++) begin
            lk_pc = DBITS'(16'h0204 + p * 16'h0004 + ((p == 3) ? 16'h00F0 : 16'h0));
            if (p == 3) lk_pc = 16'h0300;
            #1;
            n_checks++;
            if (pred_taken !== 1'b0 || pred_target !== lk_pc + 16'd2) begin
                n_fail++;
                $display("FAIL inv_all_miss pc=%h got=%b/%h expected=0/%h", lk_pc, pred_taken, pred_target, lk_pc + 16'd2);
            end
        end
    endtask

    task automatic test_reset_midsweep();
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) clock_edge();
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL midsweep_ready_low cycle=%0d got=%b expected=0", i, ready);
            end
            clock_edge();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_ready_rise got=%b expected=1", ready);
        end
    endtask

    task automatic test_saturation();
        upd_valid   = 1'b1;
        upd_pc      = 16'h0400;
        upd_taken   = 1'b0;
        upd_target  = 16'h0000;
        upd_mispred = 1'b1;
        for (int i = 0; i < 65536; i++) clock_edge();
        n_checks++;
        if (mispred_count !== 16'hFFFF || br_count !== 16'hFFFF || m_mp != 65535) begin
            n_fail++;
            $display("FAIL sat_counts got=%h/%h expected=FFFF/FFFF", br_count, mispred_count);
        end
        clock_edge();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        n_checks++;
        if (mispred_count !== 16'hFFFF || br_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold got=%h/%h expected=FFFF/FFFF", br_count, mispred_count);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_random();
        test_invalidate();
        test_reset_midsweep();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DBITS, default 16, giving the PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16, giving the BTB depth; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter CNT_ALLOC, default 2'b10, giving the counter value written on allocation by a taken branch.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports clk (input, 1): the clock; all state changes on its rising edge.
REQ-006 SHALL have port reset (input, 1): synchronous, active-high reset; starts the BTB clear sweep.
REQ-007 SHALL have ports lk_pc (input, DBITS): fetch PC; pred_taken (output, 1); pred_target (output, DBITS).
REQ-008 SHALL have ports upd_valid (input, 1), upd_pc (input, DBITS), upd_taken (input, 1), upd_target (input, DBITS) and upd_jump (input, 1); upd_jump marks an unconditional register jump.
REQ-009 SHALL have port upd_mispred (input, 1): the resolving stage flushed on this update.
REQ-010 SHALL have ports inv (input, 1): invalidate request; ready (output, 1): predictor not clearing.
REQ-011 SHALL have ports br_count (output, DBITS) and mispred_count (output, DBITS): statistics.

Function
REQ-012 SHALL derive IDX = log2(ENTRIES): index = pc[IDX:1] (2-byte instructions), tag = pc[DBITS-1:IDX+1].
REQ-013 SHALL hold per entry: valid, tag, target (DBITS) and a 2-bit saturating counter.
REQ-014 SHALL make lookup combinational on lk_pc, where hit = ready && valid && tag match; pred_taken = hit && counter[1]; pred_target = entry target when hit, else lk_pc+2.
REQ-015 SHALL, on upd_valid && ready when the entry hits, write the target from upd_target and step the counter: taken increments (saturating at 3), not-taken decrements (saturating at 0); upd_jump forces the counter to 3.
REQ-016 SHALL, on upd_valid && ready when the entry misses, allocate only if upd_taken: valid=1, new tag, target=upd_target, counter=CNT_ALLOC (3 if upd_jump); a not-taken miss leaves the entry unchanged.
REQ-017 SHALL give a same-cycle lookup and update to the same index the pre-update entry (no bypass).
REQ-018 SHALL increment br_count on each accepted update and mispred_count on each accepted update with upd_mispred; both saturate at all-ones.
REQ-019 SHALL implement FSM states CLEAR and RUN; CLEAR writes valid=0 and counter=2'b01 to index 0..ENTRIES-1, one index per cycle, then goes to RUN.
REQ-020 SHALL drive ready=0 in CLEAR, during which updates are ignored and pred_taken=0.
REQ-021 SHALL, on inv in RUN, enter CLEAR at index 0 on the next edge; an update in the same cycle as inv is discarded.
REQ-022 SHALL ignore inv while already in CLEAR (the sweep is not restarted).
REQ-023 SHALL not change statistics on inv.

Reset
REQ-024 SHALL, on reset: enter CLEAR with the sweep index at 0, set ready=0 and set br_count=mispred_count=0.
REQ-025 SHALL make ready rise exactly ENTRIES cycles after reset deasserts.
REQ-026 SHALL restart the sweep at index 0 if reset is asserted mid-sweep.

Structure
REQ-027 SHALL place the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the state encodings in a shared package, bp_pkg.
REQ-028 SHALL place the 2-bit saturating counter update in one sub-module, sat_counter2.
REQ-029 SHALL keep BTB storage as register arrays with asynchronous read and synchronous write, with no vendor memory.

Verification
REQ-030 Reset: reset 1 cycle, then ENTRIES=16 -> ready=0 for 16 cycles then 1; lookup 0x0200 -> pred_taken=0, pred_target=0x0202.
REQ-031 Allocate: update pc=0x0204, taken, target=0x0220 -> next cycle lookup 0x0204 gives pred_taken=1 and target 0x0220; br_count=1.
REQ-032 Hysteresis: taken x3 then not-taken x1 on 0x0204 -> still predicted taken; one more not-taken -> predicted not taken.
REQ-033 Alias: after allocating 0x0204, lookup 0x0224 (same index, different tag) -> miss, target 0x0226.
REQ-034 Invalidate: inv plus a simultaneous update -> update dropped, ready low 16 cycles, all lookups miss afterward; counts unchanged.
REQ-035 Saturation: force 0xFFFF mispredicted updates plus 1 -> mispred_count stays 0xFFFF.
